// File: rtl/half_adder_bist_ctrl.sv
// Built-in self-test controller for a half adder.
// Sweeps the four {a,b} patterns NUM_PASSES times, waits SETTLE_CYCLES per
// pattern, checks sum/carry against a^b / a&b and reports pass/fail status.
// Optional feature: define HA_BIST_MISR_EN to add a 4-bit response MISR whose
// final value must equal GOLDEN_SIG for pass to assert.
module half_adder_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned FAIL_W        = 8,
    parameter logic [3:0]  GOLDEN_SIG    = 4'h4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resp_s,
    input  logic              resp_c,
    output logic              test_mode,
    output logic              tpg_a,
    output logic              tpg_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [1:0]        first_fail_pat,
    output logic              first_fail_vld,
    output logic [3:0]        signature
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

    state_t            state;
    logic [1:0]        pat;
    logic [1:0]        pat_nxt;
    logic [SET_W-1:0]  set_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic              exp_s;
    logic              exp_c;
    logic              mismatch;
    logic              run_start;
    logic              capture_en;

    // Golden half-adder response for the pattern currently applied
    assign exp_s      = pat[1] ^ pat[0];
    assign exp_c      = pat[1] & pat[0];
    assign mismatch   = (resp_s != exp_s) || (resp_c != exp_c);
    assign pat_nxt    = pat + 2'd1;
    assign run_start  = ((state == IDLE) || (state == DONE)) && start;
    assign capture_en = (state == CAPTURE);

    // Sequencer: pattern stepping, settle wait, response compare and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pat            <= 2'd0;
            set_cnt        <= '0;
            pass_cnt       <= '0;
            tpg_a          <= 1'b0;
            tpg_b          <= 1'b0;
            busy           <= 1'b0;
            test_mode      <= 1'b0;
            done           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_pat <= 2'd0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= APPLY;
                        pat            <= 2'd0;
                        set_cnt        <= '0;
                        pass_cnt       <= '0;
                        tpg_a          <= 1'b0;
                        tpg_b          <= 1'b0;
                        busy           <= 1'b1;
                        test_mode      <= 1'b1;
                        done           <= 1'b0;
                        fail_cnt       <= '0;
                        first_fail_pat <= 2'd0;
                        first_fail_vld <= 1'b0;
                    end
                end
                APPLY: begin
                    set_cnt <= '0;
                    if (SETTLE_CYCLES == 0) begin
                        state <= CAPTURE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end
                CAPTURE: begin
                    if (mismatch) begin
                        if (fail_cnt != {FAIL_W{1'b1}}) begin
                            fail_cnt <= fail_cnt + FAIL_W'(1);
                        end
                        if (!first_fail_vld) begin
                            first_fail_pat <= pat;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if ((pat == 2'd3) && (pass_cnt == PASS_LAST)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        test_mode <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (pat == 2'd3) begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                        end
                        pat   <= pat_nxt;
                        tpg_a <= pat_nxt[1];
                        tpg_b <= pat_nxt[0];
                        state <= APPLY;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HA_BIST_MISR_EN
    logic [3:0] sig;

    // Response compactor: one shift per capture, cleared at the start of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 4'h0;
        end else if (run_start) begin
            sig <= 4'h0;
        end else if (capture_en) begin
            sig <= {sig[2:0], sig[3] ^ sig[2]} ^ {2'b00, resp_c, resp_s};
        end
    end

    assign signature = sig;
    assign pass      = done && (fail_cnt == '0) && (sig == GOLDEN_SIG);
`else
    logic unused_misr;

    // No compactor in this build: signature reads as zero
    assign unused_misr = (^GOLDEN_SIG) ^ run_start ^ capture_en;
    assign signature   = 4'h0;
    assign pass        = done && (fail_cnt == '0);
`endif

endmodule

// File: doc/half_adder_bist_ctrl.md
Name: half_adder_bist_ctrl

Overview:
- Built-in self-test controller for the half adder.
- Drives all four input combinations (00, 01, 10, 11) into the adder under test and waits a settle time per pattern.
- Captures sum/carry and compares them against the golden function s = a^b, c = a&b.
- Reports busy/done/pass status, a saturating fail count and the first failing pattern; sits between the test-access logic and the adder's input mux.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between applying a pattern and capturing the response (0 legal = no wait state).
- NUM_PASSES, 1, number of full 4-pattern sweeps per run (>=1).
- FAIL_W, 8, width of the fail counter.
- GOLDEN_SIG, 4'h4, expected MISR signature (MISR_EN only; 4'h4 is correct for NUM_PASSES=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled only in IDLE or DONE.
- resp_s  in  1  sum from adder under test.
- resp_c  in  1  carry from adder under test.
- test_mode  out  1  selects BIST patterns into the adder's input mux; high while busy.
- tpg_a  out  1  pattern bit a.
- tpg_b  out  1  pattern bit b.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  done & zero failures (& signature match under MISR_EN).
- fail_cnt  out  FAIL_W  number of mismatching captures; saturates at all-ones.
- first_fail_pat  out  2  {a,b} of the first mismatching capture.
- first_fail_vld  out  1  first_fail_pat is valid.
- signature  out  4  MISR contents; constant 0 without MISR_EN.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including tpg_a/tpg_b, fail_cnt, first_fail_*, signature; internal pattern, pass and settle counters cleared.
- Reset mid-run aborts immediately to IDLE with reset values; no partial result is retained.
- Pattern index pat[1:0] counts 0..3 with tpg_a = pat[1], tpg_b = pat[0], giving order 00, 01, 10, 11.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE/DONE:
  - start=1 clears fail_cnt, first_fail_*, signature, pat and the pass counter, then goes to APPLY.
  - DONE holds done=1 and pass until start.
- APPLY: 1 cycle. Pattern is driven; tpg_* are registered and change only on entry to APPLY. Goes to SETTLE, or straight to CAPTURE when SETTLE_CYCLES=0.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to CAPTURE.
- CAPTURE: 1 cycle. Samples resp_s/resp_c and compares them with the expected values for the current pat.
  - Mismatch if either bit differs.
  - On mismatch, fail_cnt increments (holds at 2^FAIL_W-1).
  - On the first mismatch of a run, first_fail_pat <= pat and first_fail_vld <= 1.
  - Next state:
    - pat==3 and last pass: DONE.
    - pat==3, not last pass: pat wraps to 0, pass counter increments, APPLY.
    - otherwise: pat increments, APPLY.
- test_mode = busy = (state is APPLY, SETTLE or CAPTURE).
- Latency: counting the edge that samples start as edge 0, done rises on edge 4*NUM_PASSES*(SETTLE_CYCLES+2).
- start while busy is ignored; start held high in DONE restarts on the next edge.
- pass is combinational from registered state; it is 0 whenever done=0.

Optional Feature:
- Macro: HA_BIST_MISR_EN.
- Defined:
  - 4-bit MISR updates once per CAPTURE: sig <= {sig[2:0], sig[3]^sig[2]} ^ {2'b00, resp_c, resp_s}.
  - Cleared on reset and start; driven on signature.
  - pass additionally requires signature == GOLDEN_SIG.
- Undefined: no MISR logic; signature tied to 0; pass depends on fail_cnt only.

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE -> all outputs 0 immediately, state IDLE; release, no start -> outputs remain 0.
- Good adder model, SETTLE_CYCLES=2, NUM_PASSES=1, pulse start -> tpg {a,b} sequence 00,01,10,11, each held 4 cycles; done at edge 16; pass=1, fail_cnt=0, first_fail_vld=0.
- Carry stuck-at-0 -> fail_cnt=1, first_fail_pat=2'b11, first_fail_vld=1, pass=0.
- Sum stuck-at-1, NUM_PASSES=3 -> fail_cnt=6, first_fail_pat=2'b00, done at edge 48.
- start pulsed repeatedly while busy -> no restart, done still at edge 16; start in DONE -> statistics cleared, new run completes identically.
- HA_BIST_MISR_EN defined:
  - Good model -> signature=4'h4, pass=1.
  - Carry stuck-at-0 -> signature=4'h6, pass=0.
